// File: rtl/ripple_add_sequencer_pkg.sv
// Shared types for the multi-word adder sequencer.
// State encoding and fixed word width of the shared adder.
package add_pkg;
   localparam int DW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/ripple_add_sequencer_if.sv
// Operand/result handshake bundle for ripple_add_sequencer.
// slave is the sequencer side, master the producer/consumer side.
interface ripple_add_sequencer_if #(
   parameter int WORDS = 4,
   parameter int DW    = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [WORDS*DW-1:0] a;
   logic [WORDS*DW-1:0] b;
   logic                c_in;
   logic                out_valid;
   logic                out_ready;
   logic [WORDS*DW-1:0] sum;
   logic                c_out;

   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out
   );

   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out
   );
endinterface

// File: rtl/ripple_adder.sv
// Purely combinational DW-bit ripple-carry adder.
// Shared by the sequencer across all operand words.
module ripple_adder #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          ci,
   output logic [DW-1:0] s,
   output logic          co
);
   logic [DW:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DW; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[DW];
   end
endmodule

// File: rtl/ripple_add_sequencer.sv
// Multi-word adder: one shared 8-bit adder, LS word first, one word per clock,
// carry chained between words through carry_q.
module ripple_add_sequencer #(
   parameter int WORDS = 4,
   parameter int DW    = add_pkg::DW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ripple_add_sequencer_if.slave  bus,
   output logic                   busy
);
   import add_pkg::*;

   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_e              state_q, state_d;
   logic [WORDS*DW-1:0] a_q, a_d;
   logic [WORDS*DW-1:0] b_q, b_d;
   logic [WORDS*DW-1:0] sum_q, sum_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d;
   logic [IW-1:0]       idx_q, idx_d;

   logic [DW-1:0]       add_a, add_b, add_s;
   logic                add_co;

   assign add_a = a_q[idx_q*DW +: DW];
   assign add_b = b_q[idx_q*DW +: DW];

   ripple_adder #(.DW(DW)) u_add (
      .a  (add_a),
      .b  (add_b),
      .ci (carry_q),
      .s  (add_s),
      .co (add_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.c_in;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*DW +: DW] = add_s;
            carry_d = add_co;
            if (idx_q == LAST) begin
               cout_d  = add_co;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.c_out     = cout_q;
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Directed and random checks for ripple_add_sequencer (WORDS=4, DW=8).
// Inputs driven and outputs sampled on the falling edge.
module tb_ripple_add_sequencer;
   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;

   ripple_add_sequencer_if #(.WORDS(4), .DW(8)) bus ();

   ripple_add_sequencer #(.WORDS(4), .DW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts an op at a negedge; lat = edges from accept to out_valid,
   // -1 on timeout, -2 if never ready.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input int stall, input bit churn,
                         input bit accept, output logic [31:0] s,
                         output logic co, output int lat);
      int w;
      s   = '0;
      co  = 1'b0;
      lat = 0;
      w   = 0;
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         lat = -2;
         return;
      end
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      bus.c_in     = cv;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < 20) begin
         if (churn) begin
            bus.a    = $urandom;
            bus.b    = $urandom;
            bus.c_in = 1'($urandom);
            bus.in_valid = 1'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (!bus.out_valid) begin
         lat = -1;
         return;
      end
      s  = bus.sum;
      co = bus.c_out;
      if (!accept) return;
      repeat (stall) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({bus.in_ready, bus.out_valid, busy, bus.c_out} !== 4'b1000 ||
          bus.sum !== 32'h0) begin
         errors++;
         $display("FAIL reset rdy/vld/busy/cout=%b sum=%h required 1000 0",
                  {bus.in_ready, bus.out_valid, busy, bus.c_out}, bus.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] s;
      logic co;
      int lat;
      run_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, s, co, lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL latency got %0d required 4", lat);
      end
      checks++;
      if ({co, s} !== {1'b0, 32'h00000100}) begin
         errors++;
         $display("FAIL basic1 got %b/%h required 0/00000100", co, s);
      end
      checks++;
      if (bus.sum !== 32'h00000100 || !bus.in_ready) begin
         errors++;
         $display("FAIL idle_hold sum=%h rdy=%b required 00000100 1",
                  bus.sum, bus.in_ready);
      end
      run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 1'b0, 1'b1, s, co, lat);
      checks++;
      if ({co, s} !== {1'b1, 32'h00000000} || lat !== 4) begin
         errors++;
         $display("FAIL carry_chain got %b/%h lat %0d required 1/00000000 4",
                  co, s, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] s;
      logic co;
      int lat;
      run_op(32'h12345678, 32'h87654321, 1'b0, 0, 1'b0, 1'b1, s, co, lat);
      checks++;
      if ({co, s} !== {1'b0, 32'h99999999} || lat !== 4) begin
         errors++;
         $display("FAIL b2b_1 got %b/%h lat %0d required 0/99999999 4",
                  co, s, lat);
      end
      run_op(32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, 1'b1, s, co, lat);
      checks++;
      if ({co, s} !== {1'b1, 32'h00000000} || lat !== 4) begin
         errors++;
         $display("FAIL b2b_2 got %b/%h lat %0d required 1/00000000 4",
                  co, s, lat);
      end
   endtask

   task automatic test_stall();
      logic [31:0] s;
      logic co;
      int lat;
      run_op(32'h0000FFFF, 32'h00FF0001, 1'b1, 0, 1'b0, 1'b0, s, co, lat);
      checks++;
      if ({co, s} !== {1'b0, 32'h01000001} || lat !== 4) begin
         errors++;
         $display("FAIL stall_res got %b/%h lat %0d required 0/01000001 4",
                  co, s, lat);
      end
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a        = 32'hDEAD0000 + i;
         bus.b        = 32'h0000BEEF;
         @(negedge clk);
         checks++;
         if (bus.sum !== 32'h01000001 || bus.c_out !== 1'b0 ||
             bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold cyc %0d sum=%h co=%b vld=%b rdy=%b",
                     i, bus.sum, bus.c_out, bus.out_valid, bus.in_ready);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_extra cyc %0d vld=%b rdy=%b required 0 1",
                     i, bus.out_valid, bus.in_ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_churn();
      logic [31:0] s;
      logic co;
      int lat;
      run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 2, 1'b1, 1'b1, s, co, lat);
      checks++;
      if ({co, s} !== {1'b1, 32'h00000000} || lat !== 4) begin
         errors++;
         $display("FAIL churn got %b/%h lat %0d required 1/00000000 4",
                  co, s, lat);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [31:0] s;
      logic co;
      int lat;
      bus.in_valid = 1'b1;
      bus.a        = 32'hFFFFFFFF;
      bus.b        = 32'hFFFFFFFF;
      bus.c_in     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, busy, bus.c_out} !== 4'b1000 ||
          bus.sum !== 32'h0) begin
         errors++;
         $display("FAIL midop_rst rdy/vld/busy/cout=%b sum=%h required 1000 0",
                  {bus.in_ready, bus.out_valid, busy, bus.c_out}, bus.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midop_partial vld=%b required 0", bus.out_valid);
      end
      run_op(32'h00000001, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, s, co, lat);
      checks++;
      if ({co, s} !== {1'b0, 32'h00000002} || lat !== 4) begin
         errors++;
         $display("FAIL post_rst got %b/%h lat %0d required 0/00000002 4",
                  co, s, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] av, bv, s;
      logic        cv, co;
      logic [32:0] exp;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         av  = $urandom;
         bv  = $urandom;
         cv  = 1'($urandom);
         if (i % 7 == 0) bv = ~av;
         exp = {1'b0, av} + {1'b0, bv} + {32'b0, cv};
         run_op(av, bv, cv, $urandom_range(0, 3), 1'(i % 2), 1'b1,
                s, co, lat);
         checks++;
         if ({co, s} !== exp || lat !== 4) begin
            errors++;
            $display("FAIL random %0d %h+%h+%b got %b/%h lat %0d required %b/%h",
                     i, av, bv, cv, co, s, lat, exp[32], exp[31:0]);
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_churn();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
